// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master drives the request and operands. The slave returns the result flags.
interface serial_subtractor_if #(
  parameter int maxn = 16
);
  logic            start;
  logic [maxn-1:0] x;
  logic [maxn-1:0] y;
  logic [maxn-1:0] diff;
  logic            borrow;
  logic            overflow;
  logic            zero;
  logic            busy;
  logic            done;

  modport master (
    output start, x, y,
    input  diff, borrow, overflow, zero, busy, done
  );

  modport slave (
    input  start, x, y,
    output diff, borrow, overflow, zero, busy, done
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial x - y, processed LSB first with one bit per clock.
// The result flags are captured together on entry to DONE and held until the next result.
module serial_subtractor #(
  parameter int maxn = 16
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);
  localparam int cw = $clog2(maxn + 1);
  localparam logic [cw-1:0] last_cnt = cw'(maxn - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  logic [maxn-1:0] x_r;
  logic [maxn-1:0] y_r;
  logic [maxn-1:0] d_r;
  logic            b_r;
  logic [cw-1:0]   cnt_r;
  logic            xmsb_r;
  logic            ymsb_r;
  logic [maxn-1:0] diff_r;
  logic            borrow_r;
  logic            overflow_r;
  logic            zero_r;
  logic            busy_r;
  logic            done_r;

  logic            d_s;
  logic            bnext_s;
  logic [maxn-1:0] diff_next_s;

  // One full-subtractor step on the current LSBs
  always_comb begin
    d_s         = x_r[0] ^ y_r[0] ^ b_r;
    bnext_s     = (~x_r[0] & y_r[0]) | (~(x_r[0] ^ y_r[0]) & b_r);
    diff_next_s = {d_s, d_r[maxn-1:1]};
  end

  // Control FSM, operand shifters and registered result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      x_r        <= {maxn{1'b0}};
      y_r        <= {maxn{1'b0}};
      d_r        <= {maxn{1'b0}};
      b_r        <= 1'b0;
      cnt_r      <= {cw{1'b0}};
      xmsb_r     <= 1'b0;
      ymsb_r     <= 1'b0;
      diff_r     <= {maxn{1'b0}};
      borrow_r   <= 1'b0;
      overflow_r <= 1'b0;
      zero_r     <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            state_r <= RUN;
            x_r     <= bus.x;
            y_r     <= bus.y;
            xmsb_r  <= bus.x[maxn-1];
            ymsb_r  <= bus.y[maxn-1];
            d_r     <= {maxn{1'b0}};
            b_r     <= 1'b0;
            cnt_r   <= {cw{1'b0}};
            busy_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        RUN: begin
          x_r <= {1'b0, x_r[maxn-1:1]};
          y_r <= {1'b0, y_r[maxn-1:1]};
          d_r <= diff_next_s;
          b_r <= bnext_s;
          // The last bit is the sign bit of the difference, so d_s feeds the overflow test
          if (cnt_r == last_cnt) begin
            state_r    <= DONE;
            diff_r     <= diff_next_s;
            borrow_r   <= bnext_s;
            overflow_r <= (xmsb_r != ymsb_r) && (d_s != xmsb_r);
            zero_r     <= (diff_next_s == {maxn{1'b0}});
            done_r     <= 1'b1;
          end else begin
            cnt_r <= cnt_r + {{(cw-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.diff     = diff_r;
  assign bus.borrow   = borrow_r;
  assign bus.overflow = overflow_r;
  assign bus.zero     = zero_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks of serial_subtractor at maxn=16.
// Outputs are sampled 1ns after each rising edge.
module tb_serial_subtractor;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  serial_subtractor_if #(.maxn(16)) bus ();

  serial_subtractor #(.maxn(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept one operation, wait for done, and check latency, flags and hold behaviour
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] ed, input logic eb, input logic eo, input logic ez);
    int n;
    bus.x = a;
    bus.y = b;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk({tag, ".busy_run"}, 32'(bus.busy), 32'd1);
    n = 0;
    while (n < 40 && bus.done !== 1'b1) begin
      step();
      n++;
    end
    chk({tag, ".latency"}, 32'(n), 32'd16);
    chk({tag, ".diff"}, 32'(bus.diff), 32'(ed));
    chk({tag, ".borrow"}, 32'(bus.borrow), 32'(eb));
    chk({tag, ".overflow"}, 32'(bus.overflow), 32'(eo));
    chk({tag, ".zero"}, 32'(bus.zero), 32'(ez));
    step();
    chk({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
    chk({tag, ".busy_idle"}, 32'(bus.busy), 32'd0);
    chk({tag, ".diff_hold"}, 32'(bus.diff), 32'(ed));
  endtask

  logic [15:0] acc_x;
  logic [15:0] acc_y;
  logic [15:0] ref_d;
  logic        prev_busy;
  int          sd;
  int          ops;
  int          cyc;
  int          last_done;
  int          ndone;

  initial begin
    checks = 0;
    failures = 0;
    acc_x = 16'h0000;
    acc_y = 16'h0000;
    rst = 1'b1;
    bus.start = 1'b1;
    bus.x = 16'h1111;
    bus.y = 16'h2222;
    step();
    step();
    chk("reset.busy", 32'(bus.busy), 32'd0);
    chk("reset.done", 32'(bus.done), 32'd0);
    chk("reset.diff", 32'(bus.diff), 32'd0);
    chk("reset.flags", {29'd0, bus.borrow, bus.overflow, bus.zero}, 32'd0);
    bus.start = 1'b0;
    rst = 1'b0;
    step();
    chk("idle.busy", 32'(bus.busy), 32'd0);

    run_op("sub_5_3", 16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 1'b0);
    run_op("sub_3_5", 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0, 1'b0);
    run_op("sub_8000_1", 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    run_op("sub_equal", 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b1);
    run_op("sub_0_0", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
    run_op("sub_0_1", 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    run_op("sub_7fff_ffff", 16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1, 1'b0);

    // A start pulse in mid-operation with new operands must be ignored
    bus.x = 16'h0010;
    bus.y = 16'h0001;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    ndone = 0;
    last_done = -1;
    for (int i = 1; i <= 40; i++) begin
      if (i == 5) begin
        bus.start = 1'b1;
        bus.x = 16'hFFFF;
        bus.y = 16'h0000;
      end
      if (i == 6) bus.start = 1'b0;
      step();
      if (bus.done === 1'b1) begin
        ndone++;
        last_done = i;
        chk("busy_start.diff", 32'(bus.diff), 32'h000F);
      end
    end
    chk("busy_start.done_count", 32'(ndone), 32'd1);
    chk("busy_start.latency", 32'(last_done), 32'd16);

    // Reset in the middle of RUN aborts the operation
    bus.x = 16'h0009;
    bus.y = 16'h0004;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 8; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort.busy", 32'(bus.busy), 32'd0);
    chk("abort.done", 32'(bus.done), 32'd0);
    chk("abort.diff", 32'(bus.diff), 32'd0);
    chk("abort.flags", {29'd0, bus.borrow, bus.overflow, bus.zero}, 32'd0);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.done === 1'b1) ndone++;
    end
    chk("abort.no_done", 32'(ndone), 32'd0);
    run_op("after_abort", 16'h0009, 16'h0004, 16'h0005, 1'b0, 1'b0, 1'b0);

    // Back-to-back operations with start held high, checked against integer arithmetic
    bus.x = 16'($urandom);
    bus.y = 16'($urandom);
    bus.start = 1'b1;
    prev_busy = bus.busy;
    ops = 0;
    cyc = 0;
    last_done = -1;
    while (ops < 200 && cyc < 10000) begin
      step();
      cyc++;
      if (prev_busy !== 1'b1 && bus.busy === 1'b1) begin
        acc_x = bus.x;
        acc_y = bus.y;
        bus.x = 16'($urandom);
        bus.y = 16'($urandom);
      end
      if (bus.done === 1'b1) begin
        ref_d = acc_x - acc_y;
        sd = int'($signed(acc_x)) - int'($signed(acc_y));
        chk("rand.diff", 32'(bus.diff), 32'(ref_d));
        chk("rand.borrow", 32'(bus.borrow), 32'(acc_x < acc_y));
        chk("rand.overflow", 32'(bus.overflow), 32'((sd > 32767) || (sd < -32768)));
        chk("rand.zero", 32'(bus.zero), 32'(acc_x == acc_y));
        if (last_done >= 0) chk("rand.spacing", 32'(cyc - last_done), 32'd18);
        last_done = cyc;
        ops++;
      end
      prev_busy = bus.busy;
    end
    bus.start = 1'b0;
    chk("rand.ops_completed", 32'(ops), 32'd200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
